// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing one cdc_fifo write port among several write-domain requesters.
// Grants are held for a burst that ends on the requester's last beat or after max_burst beats.
module cdc_fifo_write_arbiter #(
   parameter int unsigned num_requesters = 4,
   parameter int unsigned data_width     = 32,
   parameter int unsigned max_burst      = 16,
   localparam int unsigned id_width      = $clog2(num_requesters)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [num_requesters*data_width-1:0] req_data,
   input  logic [num_requesters-1:0]            req_valid,
   input  logic [num_requesters-1:0]            req_last,
   output logic [num_requesters-1:0]            req_ready,
   output logic [id_width+data_width-1:0]       fifo_write_data,
   output logic                                 fifo_write_valid,
   input  logic                                 fifo_write_ready,
   output logic [id_width-1:0]                  grant_id,
   output logic                                 busy
);

   localparam int unsigned cnt_width = $clog2(max_burst + 1);
   localparam logic [cnt_width-1:0] last_count = cnt_width'(max_burst - 1);
   localparam logic [id_width-1:0] top_id = id_width'(num_requesters - 1);

   typedef enum logic {StIdle, StBurst} state_t;

   state_t                state;
   logic [id_width-1:0]   rr_ptr;
   logic [cnt_width-1:0]  burst_count;
   logic [id_width-1:0]   winner;
   logic [id_width-1:0]   cand;
   logic                  found;
   logic                  accept;
   logic                  release_grant;
   logic [data_width-1:0] payload [num_requesters];

   for (genvar i = 0; i < num_requesters; i++) begin : g_payload
      assign payload[i] = req_data[i*data_width +: data_width];
   end

   // Search starts one past the last grant and wraps, so the previous winner is checked last.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      cand   = rr_ptr;
      for (int k = 0; k < num_requesters; k++) begin
         cand = (cand == top_id) ? '0 : cand + 1'b1;
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      req_ready        = '0;
      fifo_write_valid = 1'b0;
      fifo_write_data  = '0;
      if (state == StBurst) begin
         req_ready[grant_id] = fifo_write_ready;
         fifo_write_valid    = req_valid[grant_id];
         fifo_write_data     = {grant_id, payload[grant_id]};
      end
   end

   assign accept        = (state == StBurst) && fifo_write_valid && fifo_write_ready;
   assign release_grant = req_last[grant_id] || (burst_count == last_count);
   assign busy          = (state == StBurst);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         grant_id    <= '0;
         rr_ptr      <= top_id;
         burst_count <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (found) begin
                  state       <= StBurst;
                  grant_id    <= winner;
                  rr_ptr      <= winner;
                  burst_count <= '0;
               end
            end
            StBurst: begin
               if (accept) begin
                  if (release_grant) begin
                     state <= StIdle;
                  end else begin
                     burst_count <= burst_count + 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Self-checking bench for cdc_fifo_write_arbiter: directed scenarios plus a randomized
// per-requester scoreboard (4 requesters, 8-bit payload, max_burst = 4).
module tb_cdc_fifo_write_arbiter;

   localparam int unsigned nr = 4;
   localparam int unsigned dw = 8;
   localparam int unsigned mb = 4;
   localparam int unsigned plen = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   req_data;
   logic [3:0]    req_valid;
   logic [3:0]    req_last;
   logic [3:0]    req_ready;
   logic [9:0]    fifo_write_data;
   logic          fifo_write_valid;
   logic          fifo_write_ready;
   logic [1:0]    grant_id;
   logic          busy;
   logic [7:0]    drv_data [4];

   int check_count = 0;
   int pass_count  = 0;

   assign req_data = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};

   cdc_fifo_write_arbiter #(
      .num_requesters(nr),
      .data_width    (dw),
      .max_burst     (mb)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_data        (req_data),
      .req_valid       (req_valid),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .fifo_write_data (fifo_write_data),
      .fifo_write_valid(fifo_write_valid),
      .fifo_write_ready(fifo_write_ready),
      .grant_id        (grant_id),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req_valid        = '0;
      req_last         = '0;
      fifo_write_ready = 1'b0;
      for (int i = 0; i < 4; i++) drv_data[i] = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset            = 1'b1;
      req_valid        = 4'hF;
      req_last         = 4'hF;
      fifo_write_ready = 1'b1;
      for (int i = 0; i < 4; i++) drv_data[i] = 8'(8'h10 + i);
      settle();
      check_count++;
      if (req_ready !== 4'h0) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      else pass_count++;
      check_count++;
      if (fifo_write_valid !== 1'b0) $display("FAIL reset_fifo_valid: got %b want 0", fifo_write_valid);
      else pass_count++;
      check_count++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else pass_count++;
      check_count++;
      if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id);
      else pass_count++;
      check_count++;
      if (fifo_write_data !== 10'h0) $display("FAIL reset_fifo_data: got %h want 000", fifo_write_data);
      else pass_count++;
      reset = 1'b0;
      next_cycle();
      settle();
      check_count++;
      if (busy !== 1'b1 || grant_id !== 2'd0)
         $display("FAIL reset_first_grant: got busy=%b id=%0d want busy=1 id=0", busy, grant_id);
      else pass_count++;
      check_count++;
      if (req_ready !== 4'b0001 || fifo_write_data !== {2'd0, 8'h10})
         $display("FAIL reset_first_beat: got ready=%b data=%h want 0001 010", req_ready, fifo_write_data);
      else pass_count++;
      next_cycle();
      req_valid = '0;
      settle();
      check_count++;
      if (busy !== 1'b0) $display("FAIL reset_release: got busy=%b want 0", busy);
      else pass_count++;
   endtask

   task automatic test_single_burst();
      logic [7:0] beats [3];
      beats[0] = 8'hA1;
      beats[1] = 8'hA2;
      beats[2] = 8'hA3;
      do_reset();
      req_valid        = 4'b0100;
      drv_data[2]      = beats[0];
      fifo_write_ready = 1'b1;
      settle();
      check_count++;
      if (busy !== 1'b0 || fifo_write_valid !== 1'b0)
         $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy, fifo_write_valid);
      else pass_count++;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         drv_data[2] = beats[k];
         req_last[2] = (k == 2);
         settle();
         check_count++;
         if (busy !== 1'b1 || fifo_write_valid !== 1'b1 || req_ready !== 4'b0100 ||
             fifo_write_data !== {2'd2, beats[k]})
            $display("FAIL single_beat%0d: got busy=%b valid=%b ready=%b data=%h want 1 1 0100 %h",
                     k, busy, fifo_write_valid, req_ready, fifo_write_data, {2'd2, beats[k]});
         else pass_count++;
         next_cycle();
      end
      req_valid = '0;
      req_last  = '0;
      settle();
      check_count++;
      if (busy !== 1'b0 || fifo_write_valid !== 1'b0)
         $display("FAIL single_end: got busy=%b valid=%b want 0 0", busy, fifo_write_valid);
      else pass_count++;
   endtask

   task automatic test_round_robin();
      logic [1:0] eid;
      logic [7:0] ed;
      do_reset();
      req_valid        = 4'hF;
      req_last         = 4'hF;
      fifo_write_ready = 1'b1;
      for (int i = 0; i < 4; i++) drv_data[i] = 8'(8'h30 + i);
      for (int c = 0; c < 12; c++) begin
         settle();
         check_count++;
         if (c % 2 == 0) begin
            if (busy !== 1'b0 || fifo_write_valid !== 1'b0)
               $display("FAIL rr_idle_c%0d: got busy=%b valid=%b want 0 0", c, busy, fifo_write_valid);
            else pass_count++;
         end else begin
            eid = 2'((c - 1) / 2);
            ed  = 8'(8'h30 + eid);
            if (busy !== 1'b1 || grant_id !== eid || fifo_write_data !== {eid, ed})
               $display("FAIL rr_grant_c%0d: got busy=%b id=%0d data=%h want 1 %0d %h",
                        c, busy, grant_id, fifo_write_data, eid, {eid, ed});
            else pass_count++;
         end
         next_cycle();
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int         rdy_s [9] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
      int         idx_s [9] = '{0, 1, 2, 2, 2, 2, 2, 2, 3};
      logic [9:0] got [$];
      logic [7:0] b;
      do_reset();
      req_valid        = 4'b0010;
      drv_data[1]      = 8'hB1;
      fifo_write_ready = 1'b1;
      settle();
      next_cycle();
      for (int c = 0; c < 9; c++) begin
         b                = 8'(8'hB1 + idx_s[c]);
         drv_data[1]      = b;
         req_last[1]      = (idx_s[c] == 3);
         fifo_write_ready = (rdy_s[c] != 0);
         settle();
         check_count++;
         if (busy !== 1'b1 || fifo_write_valid !== 1'b1 || fifo_write_data !== {2'd1, b} ||
             req_ready !== (rdy_s[c] != 0 ? 4'b0010 : 4'b0000))
            $display("FAIL bp_cycle%0d: got busy=%b valid=%b ready=%b data=%h want 1 1 %b %h",
                     c, busy, fifo_write_valid, req_ready, fifo_write_data,
                     (rdy_s[c] != 0 ? 4'b0010 : 4'b0000), {2'd1, b});
         else pass_count++;
         if (fifo_write_valid && fifo_write_ready) got.push_back(fifo_write_data);
         next_cycle();
      end
      req_valid = '0;
      req_last  = '0;
      settle();
      check_count++;
      if (busy !== 1'b0) $display("FAIL bp_release: got busy=%b want 0", busy);
      else pass_count++;
      check_count++;
      if (got.size() != 4) $display("FAIL bp_count: got %0d beats want 4", got.size());
      else pass_count++;
      for (int k = 0; k < 4; k++) begin
         check_count++;
         if (k >= got.size()) $display("FAIL bp_order%0d: got none want %h", k, {2'd1, 8'(8'hB1 + k)});
         else if (got[k] !== {2'd1, 8'(8'hB1 + k)})
            $display("FAIL bp_order%0d: got %h want %h", k, got[k], {2'd1, 8'(8'hB1 + k)});
         else pass_count++;
      end
   endtask

   task automatic test_forced_release();
      logic [9:0] got [$];
      logic [9:0] exp [11];
      logic [3:0] acc;
      int         pos0;
      bit         done3;
      for (int k = 0; k < 4; k++) exp[k] = {2'd0, 8'(8'h50 + k)};
      exp[4] = {2'd3, 8'hD3};
      for (int k = 4; k < 10; k++) exp[k+1] = {2'd0, 8'(8'h50 + k)};
      do_reset();
      fifo_write_ready = 1'b1;
      pos0  = 0;
      done3 = 1'b0;
      for (int c = 0; c < 60 && got.size() < 11; c++) begin
         drv_data[0]  = 8'(8'h50 + pos0);
         req_valid[0] = (pos0 < 10);
         req_last[0]  = 1'b0;
         drv_data[3]  = 8'hD3;
         req_valid[3] = !done3;
         req_last[3]  = 1'b1;
         settle();
         if (fifo_write_valid && fifo_write_ready) got.push_back(fifo_write_data);
         acc = req_ready & req_valid;
         next_cycle();
         if (acc[0]) pos0++;
         if (acc[3]) done3 = 1'b1;
      end
      req_valid = '0;
      check_count++;
      if (got.size() != 11) $display("FAIL forced_count: got %0d beats want 11", got.size());
      else pass_count++;
      for (int k = 0; k < 11; k++) begin
         check_count++;
         if (k >= got.size()) $display("FAIL forced_seq%0d: got none want %h", k, exp[k]);
         else if (got[k] !== exp[k]) $display("FAIL forced_seq%0d: got %h want %h", k, got[k], exp[k]);
         else pass_count++;
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_valid        = 4'b0100;
      drv_data[2]      = 8'hC1;
      fifo_write_ready = 1'b1;
      settle();
      next_cycle();
      next_cycle();
      drv_data[2] = 8'hC2;
      settle();
      check_count++;
      if (fifo_write_valid !== 1'b1 || fifo_write_data !== {2'd2, 8'hC2})
         $display("FAIL midrst_beat2: got valid=%b data=%h want 1 %h", fifo_write_valid,
                  fifo_write_data, {2'd2, 8'hC2});
      else pass_count++;
      reset = 1'b1;
      #1;
      check_count++;
      if (req_ready !== 4'h0 || fifo_write_valid !== 1'b0 || busy !== 1'b0 ||
          fifo_write_data !== 10'h0)
         $display("FAIL midrst_immediate: got ready=%b valid=%b busy=%b data=%h want 0 0 0 000",
                  req_ready, fifo_write_valid, busy, fifo_write_data);
      else pass_count++;
      next_cycle();
      reset     = 1'b0;
      req_valid = 4'b0110;
      drv_data[1] = 8'hC9;
      settle();
      check_count++;
      if (busy !== 1'b0) $display("FAIL midrst_idle: got busy=%b want 0", busy);
      else pass_count++;
      next_cycle();
      settle();
      check_count++;
      if (busy !== 1'b1 || grant_id !== 2'd1)
         $display("FAIL midrst_regrant: got busy=%b id=%0d want 1 1", busy, grant_id);
      else pass_count++;
      req_valid = '0;
   endtask

   task automatic test_random();
      logic [7:0] pkt_data [4][plen];
      bit         pkt_last [4][plen];
      int         pos [4];
      int         delivered;
      int         beats_in_grant;
      bit         must_release;
      int         id;
      logic [3:0] acc;
      bit         fire;
      for (int i = 0; i < 4; i++) begin
         pos[i] = 0;
         for (int k = 0; k < plen; k++) begin
            pkt_data[i][k] = 8'($urandom);
            pkt_last[i][k] = (k == plen - 1) || ($urandom_range(0, 3) == 0);
         end
      end
      delivered      = 0;
      beats_in_grant = 0;
      must_release   = 1'b0;
      do_reset();
      for (int c = 0; c < 3000 && delivered < 4 * plen; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (pos[i] < plen) begin
               req_valid[i] = ($urandom_range(0, 9) < 7);
               drv_data[i]  = pkt_data[i][pos[i]];
               req_last[i]  = pkt_last[i][pos[i]];
            end else begin
               req_valid[i] = 1'b0;
               drv_data[i]  = 8'h00;
               req_last[i]  = 1'b0;
            end
         end
         fifo_write_ready = ($urandom_range(0, 3) != 0);
         settle();
         if (must_release) begin
            check_count++;
            if (busy !== 1'b0) $display("FAIL rand_release_c%0d: got busy=%b want 0", c, busy);
            else pass_count++;
            must_release = 1'b0;
         end
         if (!busy) beats_in_grant = 0;
         check_count++;
         if ($countones(req_ready) > 1) $display("FAIL rand_onehot_c%0d: got ready=%b want <=1 bit", c, req_ready);
         else pass_count++;
         acc  = req_ready & req_valid;
         fire = fifo_write_valid && fifo_write_ready;
         check_count++;
         if ((|acc) !== fire)
            $display("FAIL rand_handshake_c%0d: got ready&valid=%b fifo_fire=%b want agreement", c, acc, fire);
         else pass_count++;
         if (|acc) begin
            id = 0;
            for (int i = 0; i < 4; i++) if (acc[i]) id = i;
            check_count++;
            if (fifo_write_data !== {2'(id), pkt_data[id][pos[id]]})
               $display("FAIL rand_data_c%0d: got %h want %h", c, fifo_write_data,
                        {2'(id), pkt_data[id][pos[id]]});
            else pass_count++;
            beats_in_grant++;
            check_count++;
            if (beats_in_grant > mb) $display("FAIL rand_burst_len_c%0d: got %0d want <=%0d", c, beats_in_grant, mb);
            else pass_count++;
            must_release = pkt_last[id][pos[id]] || (beats_in_grant == mb);
            pos[id]++;
            delivered++;
         end
         next_cycle();
      end
      req_valid = '0;
      check_count++;
      if (delivered != 4 * plen) $display("FAIL rand_delivered: got %0d want %0d", delivered, 4 * plen);
      else pass_count++;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_forced_release();
      test_reset_mid_burst();
      test_random();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
